mfhwt_iimg: RTL and testbench
=============================

MFHWT_IIMG -- requirements
Module: mfhwt_iimg

Interface
REQ-001 SHALL have parameter IMG_W, default 40, meaning pixels per row of the downsampled image; legal range 4..1024.
REQ-002 SHALL have parameter IMG_H, default 30, meaning rows per frame; legal range 1..1024.
REQ-003 SHALL have parameter II_W, default 32, meaning integral-value output width.
REQ-004 SHALL have port iClk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port iReset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port iInput_ready  input  1  pixel-valid strobe; one pixel per asserted cycle; back-to-back allowed.
REQ-007 SHALL have port iData_in  input  16  unsigned pixel from the upstream mfhwt output.
REQ-008 SHALL have port iSof  input  1  start-of-frame resync strobe.
REQ-009 SHALL have port oOutput_ready  output  1  integral-value valid strobe.
REQ-010 SHALL have port oData_out  output  II_W  integral-image value.
REQ-011 SHALL have port oCol  output  10  column of the current oData_out.
REQ-012 SHALL have port oRow  output  10  row of the current oData_out.
REQ-013 SHALL have port oFrame_done  output  1  pulse marking the frame's last integral value.

Function
REQ-014 SHALL compute II(r,c) = sum of all pixels p(i,j) with i<=r and j<=c within the current frame.
REQ-015 SHALL keep a running row sum: RS(r,c) = (c==0 ? 0 : RS(r,c-1)) + p(r,c).
REQ-016 SHALL keep a line buffer of IMG_W entries x II_W bits holding the previous row's II values; II(r,c) = RS(r,c) + (r==0 ? 0 : LB[c]), then LB[c] <= II(r,c).
REQ-017 SHALL use a 2-stage pipeline: accepted pixel at cycle t -> oOutput_ready=1 with its result at cycle t+2; fixed latency independent of input gaps.
REQ-018 SHALL keep the line buffer read-before-write safe for every cycle pattern; IMG_W>=4 guarantees no same-column read/write collision inside the pipeline.
REQ-019 SHALL perform all additions modulo 2^II_W with no saturation and no overflow flag.
REQ-020 SHALL advance column counter per accepted pixel; at IMG_W-1 wrap to 0 and increment row; at (IMG_H-1, IMG_W-1) wrap both to 0.
REQ-021 SHALL assert oFrame_done for exactly the one cycle whose oOutput_ready carries II(IMG_H-1, IMG_W-1); oFrame_done=0 at all other times.
REQ-022 SHALL hold oData_out, oCol, oRow stable when oOutput_ready=0 (last valid values retained).
REQ-023 SHALL, on iSof=1, force column and row counters to 0 and clear the row sum; pixels already in the pipeline complete normally.
REQ-024 SHALL, on iSof=1 with iInput_ready=1 in the same cycle, treat that pixel as p(0,0) of a new frame.
REQ-025 SHALL ignore iData_in whenever iInput_ready=0.

Reset
REQ-026 SHALL, while iReset=1, drive oOutput_ready=0, oFrame_done=0, oData_out=0, oCol=0, oRow=0, and clear counters, row sum and pipeline valid bits.
REQ-027 SHALL not reset line buffer contents; row 0 never reads them, so stale data has no effect.
REQ-028 SHALL, on iReset asserted mid-frame, discard in-flight pixels (no oOutput_ready for them) and start the next accepted pixel at (0,0).
REQ-029 SHALL give iReset priority over iSof and iInput_ready.

Verification
REQ-030 SHALL cover IMG_W=4, IMG_H=3, 12 pixels of value 1 back-to-back -> outputs 1,2,3,4,2,4,6,8,3,6,9,12 each 2 cycles after input; oFrame_done only with 12.
REQ-031 SHALL cover same frame with random 0-5 idle cycles between pixels -> identical value sequence, each exactly 2 cycles after its input.
REQ-032 SHALL cover 12 pixels of 0xFFFF, IMG_W=4, IMG_H=3 -> final output 786420, oCol=3, oRow=2, oFrame_done=1.
REQ-033 SHALL cover iSof asserted with 6th pixel of a frame of ones -> that pixel outputs 1 at (0,0); following pixels follow REQ-030 sequence.
REQ-034 SHALL cover iReset pulsed after 5 pixels, then 12 pixels of value 2 -> no outputs for discarded pixels; results 2,4,6,8,4,8,...,24 from (0,0).
REQ-035 SHALL cover II_W=8, 12 pixels of 0xFF (IMG_W=4, IMG_H=3) -> final output (12*255) mod 256 = 244, no saturation.

Source files
------------

// File: rtl/mfhwt_iimg.sv
// Integral-image generator for the downsampled mfhwt pixel stream.
// A pixel accepted in cycle t produces its integral value in cycle t+2.
// All sums wrap modulo 2^II_W.
module mfhwt_iimg #(
    parameter int IMG_W = 40,
    parameter int IMG_H = 30,
    parameter int II_W  = 32
) (
    input  logic            iClk,
    input  logic            iReset,
    input  logic            iInput_ready,
    input  logic [15:0]     iData_in,
    input  logic            iSof,
    output logic            oOutput_ready,
    output logic [II_W-1:0] oData_out,
    output logic [9:0]      oCol,
    output logic [9:0]      oRow,
    output logic            oFrame_done
);

    localparam int DATA_W = 16;
    localparam int AW     = $clog2(IMG_W);
    localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);

    // Zero-extend or truncate a pixel to the integral width (truncation is
    // exact because every sum is taken modulo 2^II_W anyway).
    function automatic logic [II_W-1:0] fitPix(input logic [DATA_W-1:0] p);
        logic [II_W+DATA_W-1:0] ext;
        ext = {{II_W{1'b0}}, p};
        return ext[II_W-1:0];
    endfunction

    // Wrapping addition: no saturation, carry out is dropped.
    function automatic logic [II_W-1:0] addWrap(input logic [II_W-1:0] a,
                                                input logic [II_W-1:0] b);
        return a + b;
    endfunction

    logic [9:0]      colCnt, rowCnt;
    logic [II_W-1:0] rowSum;
    logic [9:0]      colCur, rowCur;
    logic [II_W-1:0] rsNext;
    logic            isLast;

    logic            vld_p0, last_p0;
    logic [II_W-1:0] rs_p0;
    logic [9:0]      col_p0, row_p0;

    logic [II_W-1:0] lineBuf [IMG_W];
    logic [II_W-1:0] lbRd_p1, ii_p1;

    // Stage 0 input side: position of the incoming pixel (iSof forces 0,0)
    // and its running row sum.
    always_comb begin
        colCur = iSof ? 10'd0 : colCnt;
        rowCur = iSof ? 10'd0 : rowCnt;
        rsNext = addWrap((colCur == 10'd0) ? '0 : rowSum, fitPix(iData_in));
        isLast = (rowCur == ROW_LAST) && (colCur == COL_LAST);
    end

    // Raster counters, row sum and stage-0 valid; reset wins over iSof/pixel.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            colCnt  <= '0;
            rowCnt  <= '0;
            rowSum  <= '0;
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else begin
            vld_p0  <= iInput_ready;
            last_p0 <= iInput_ready && isLast;
            if (iInput_ready) begin
                rowSum <= rsNext;
                if (colCur == COL_LAST) begin
                    colCnt <= '0;
                    rowCnt <= (rowCur == ROW_LAST) ? 10'd0 : rowCur + 10'd1;
                end else begin
                    colCnt <= colCur + 10'd1;
                    rowCnt <= rowCur;
                end
            end else if (iSof) begin
                colCnt <= '0;
                rowCnt <= '0;
                rowSum <= '0;
            end
        end
    end

    // ---- stage 0 -> stage 1 boundary: row sum and position of the pixel
    // Stage-0 data capture, qualified only by the pixel strobe.
    always_ff @(posedge iClk) begin
        if (iInput_ready) begin
            rs_p0  <= rsNext;
            col_p0 <= colCur;
            row_p0 <= rowCur;
        end
    end

    // Stage 1: add the previous row's integral value from the line buffer.
    // The write for column c lands on the same edge that registers the
    // output, so any later pixel always reads the updated entry.
    always_comb begin
        lbRd_p1 = lineBuf[col_p0[AW-1:0]];
        ii_p1   = addWrap(rs_p0, (row_p0 == 10'd0) ? '0 : lbRd_p1);
    end

    // Line buffer update; contents are never cleared since row 0 ignores them.
    always_ff @(posedge iClk) begin
        if (vld_p0) begin
            lineBuf[col_p0[AW-1:0]] <= ii_p1;
        end
    end

    // ---- stage 1 -> output boundary: registered result, held while idle
    // Output registers; data and position only change with a valid result.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            oOutput_ready <= 1'b0;
            oFrame_done   <= 1'b0;
            oData_out     <= '0;
            oCol          <= '0;
            oRow          <= '0;
        end else begin
            oOutput_ready <= vld_p0;
            oFrame_done   <= vld_p0 && last_p0;
            if (vld_p0) begin
                oData_out <= ii_p1;
                oCol      <= col_p0;
                oRow      <= row_p0;
            end
        end
    end

endmodule

// File: tb/tb_mfhwt_iimg.sv
// Self-checking bench for mfhwt_iimg: a rectangle-sum reference model
// predicts every output two cycles after its pixel; two DUT copies (32-bit
// and 8-bit integral width) share the same stimulus.
module tb_mfhwt_iimg;

    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        iReset = 1'b1;
    logic        iInput_ready = 1'b0;
    logic [15:0] iData_in = '0;
    logic        iSof = 1'b0;

    logic        oRdy32, oDone32, oRdy8, oDone8;
    logic [31:0] oData32;
    logic [7:0]  oData8;
    logic [9:0]  oCol32, oRow32, oCol8, oRow8;

    always #5 clk = ~clk;

    mfhwt_iimg #(.IMG_W(W), .IMG_H(H), .II_W(32)) dut32 (
        .iClk(clk), .iReset(iReset), .iInput_ready(iInput_ready),
        .iData_in(iData_in), .iSof(iSof), .oOutput_ready(oRdy32),
        .oData_out(oData32), .oCol(oCol32), .oRow(oRow32), .oFrame_done(oDone32)
    );

    mfhwt_iimg #(.IMG_W(W), .IMG_H(H), .II_W(8)) dut8 (
        .iClk(clk), .iReset(iReset), .iInput_ready(iInput_ready),
        .iData_in(iData_in), .iSof(iSof), .oOutput_ready(oRdy8),
        .oData_out(oData8), .oCol(oCol8), .oRow(oRow8), .oFrame_done(oDone8)
    );

    typedef struct {
        int     due;
        longint ii;
        int     c;
        int     r;
        bit     done;
    } exp_t;

    exp_t        q[$];
    longint      img[H][W];
    int          mr = 0, mc = 0;
    longint      lastD = 0;
    int          lastC = 0, lastR = 0;
    logic [31:0] log32[$];
    int          cyc = 0;
    bit          checkEn = 1'b0;
    int          checks = 0, errors = 0;

    int onesSeq[12] = '{1, 2, 3, 4, 2, 4, 6, 8, 3, 6, 9, 12};
    int twosSeq[12] = '{2, 4, 6, 8, 4, 8, 12, 16, 6, 12, 18, 24};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: integral value is the plain sum of the rectangle (0,0)..(r,c).
    task automatic modelAccept(input logic [15:0] v, input bit sof);
        exp_t   e;
        longint s;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = longint'(v);
        s = 0;
        for (int i = 0; i <= mr; i++)
            for (int j = 0; j <= mc; j++)
                s += img[i][j];
        e.due  = cyc + 2;
        e.ii   = s;
        e.c    = mc;
        e.r    = mr;
        e.done = (mr == H - 1) && (mc == W - 1);
        q.push_back(e);
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    // Per-cycle comparison of both DUTs against the model queue.
    always @(posedge clk) begin
        #1;
        if (checkEn) begin
            bit   expV;
            exp_t e;
            expV = (q.size() > 0) && (q[0].due == cyc);
            chk("ready32", longint'(oRdy32), longint'(expV));
            chk("ready8", longint'(oRdy8), longint'(expV));
            if (expV) begin
                e = q.pop_front();
                lastD = e.ii;
                lastC = e.c;
                lastR = e.r;
                chk("done32", longint'(oDone32), longint'(e.done));
                chk("done8", longint'(oDone8), longint'(e.done));
                log32.push_back(oData32);
            end else begin
                chk("done32_idle", longint'(oDone32), 0);
                chk("done8_idle", longint'(oDone8), 0);
            end
            chk("data32", longint'(oData32), lastD & 64'hFFFF_FFFF);
            chk("data8", longint'(oData8), lastD & 64'hFF);
            chk("col32", longint'(oCol32), longint'(lastC));
            chk("row32", longint'(oRow32), longint'(lastR));
            chk("col8", longint'(oCol8), longint'(lastC));
            chk("row8", longint'(oRow8), longint'(lastR));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            iInput_ready = 1'b0;
            iSof = 1'b0;
            iData_in = 16'($urandom);
        end
    endtask

    task automatic pix(input logic [15:0] v, input bit sof);
        @(negedge clk);
        iInput_ready = 1'b1;
        iSof = sof;
        iData_in = v;
        modelAccept(v, sof);
    endtask

    task automatic sofIdle();
        @(negedge clk);
        iInput_ready = 1'b0;
        iSof = 1'b1;
        iData_in = 16'($urandom);
        mr = 0;
        mc = 0;
    endtask

    // Reset with a pixel and iSof also asserted: reset must win.
    task automatic doReset();
        @(negedge clk);
        iReset = 1'b1;
        iInput_ready = 1'b1;
        iSof = 1'b1;
        iData_in = 16'h1234;
        q.delete();
        log32.delete();
        mr = 0;
        mc = 0;
        lastD = 0;
        lastC = 0;
        lastR = 0;
        @(negedge clk);
        chk("rst_ready", longint'(oRdy32), 0);
        chk("rst_done", longint'(oDone32), 0);
        chk("rst_data", longint'(oData32), 0);
        chk("rst_col", longint'(oCol32), 0);
        chk("rst_row", longint'(oRow32), 0);
        iReset = 1'b0;
        iInput_ready = 1'b0;
        iSof = 1'b0;
    endtask

    task automatic chkSeq(input string nm, input int exp[12]);
        int base;
        base = log32.size() - 12;
        if (base < 0) begin
            chk({nm, "_count"}, longint'(log32.size()), 12);
        end else begin
            for (int i = 0; i < 12; i++)
                chk(nm, longint'(log32[base + i]), longint'(exp[i]));
        end
    endtask

    initial begin
        doReset();
        checkEn = 1'b1;

        // Twelve ones back-to-back.
        for (int i = 0; i < 12; i++) pix(16'd1, 1'b0);
        idle(4);
        chk("ones_count", longint'(log32.size()), 12);
        chkSeq("ones_seq", onesSeq);

        // Same frame with random gaps.
        log32.delete();
        for (int i = 0; i < 12; i++) begin
            pix(16'd1, 1'b0);
            idle($urandom_range(0, 5));
        end
        idle(4);
        chkSeq("gaps_seq", onesSeq);

        // Full-scale pixels.
        log32.delete();
        for (int i = 0; i < 12; i++) pix(16'hFFFF, 1'b0);
        idle(4);
        chk("max_final", longint'(oData32), 786420);
        chk("max_col", longint'(oCol32), 3);
        chk("max_row", longint'(oRow32), 2);

        // 0xFF pixels on the 8-bit instance wrap instead of saturating.
        for (int i = 0; i < 12; i++) pix(16'h00FF, 1'b0);
        idle(4);
        chk("wrap8_final", longint'(oData8), 244);

        // Start-of-frame on the 6th pixel restarts at (0,0).
        log32.delete();
        for (int i = 0; i < 5; i++) pix(16'd1, 1'b0);
        pix(16'd1, 1'b1);
        for (int i = 0; i < 11; i++) pix(16'd1, 1'b0);
        idle(4);
        chk("sof_count", longint'(log32.size()), 17);
        chkSeq("sof_seq", onesSeq);

        // Reset mid-frame discards in-flight pixels.
        for (int i = 0; i < 5; i++) pix(16'd1, 1'b0);
        doReset();
        for (int i = 0; i < 12; i++) pix(16'd2, 1'b0);
        idle(4);
        chk("rst2_count", longint'(log32.size()), 12);
        chkSeq("rst2_seq", twosSeq);

        // Random frames with gaps and occasional resyncs.
        for (int n = 0; n < 120; n++) begin
            int k;
            k = $urandom_range(0, 19);
            if (k == 0) sofIdle();
            else pix(16'($urandom), (k == 1));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(5);
        chk("drain", longint'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
